// File: rtl/conv_pe_feeder.sv
// conv_pe_feeder: loads Tin filter words, pulses change_filter, then streams an H x W IFM tile
// as zero-padded 3-row windows with delayed edge flags and t_cal_start to conv_pe.
module conv_pe_feeder #(
  parameter int K          = 3,
  parameter int IFM_DW     = 32,
  parameter int FILTER_DW  = 72,
  parameter int Tin        = 4,
  parameter int Tout       = 4,
  parameter int W_SIZE     = 10,
  parameter int FLAG_DELAY = 2,
  parameter int CAL_DELAY  = 3
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [W_SIZE-1:0]         cfg_width,
  input  logic [W_SIZE-1:0]         cfg_height,
  output logic                      busy,
  output logic                      done,
  output logic                      flt_rd_en,
  output logic [1:0]                flt_rd_idx,
  input  logic [Tout*FILTER_DW-1:0] flt_rd_data,
  output logic                      ifm_rd_en,
  output logic [W_SIZE-1:0]         ifm_rd_row,
  output logic [W_SIZE-1:0]         ifm_rd_col,
  input  logic [K*IFM_DW-1:0]       ifm_rd_data,
  output logic                      load_filter,
  output logic [1:0]                load_idx,
  output logic [Tout*FILTER_DW-1:0] bm_filter_data_flat,
  output logic                      change_filter,
  output logic                      t_data_run,
  output logic                      t_cal_start,
  output logic [K*IFM_DW-1:0]       bm_ifm_data_flat,
  output logic                      c_is_first_row,
  output logic                      c_is_last_row,
  output logic                      c_is_first_col,
  output logic                      c_is_last_col
);
  localparam int D = (FLAG_DELAY > CAL_DELAY ? FLAG_DELAY : CAL_DELAY) + 1;
  typedef enum logic [2:0] {IDLE, LOADF, GAP, CHG, RUN, DRAIN, DONE} state_e;
  state_e state_q, state_d;
  logic [1:0] cnt_q, ld_idx_q;
  logic [W_SIZE-1:0] w_q, h_q, r_q, c_q;
  logic ld_q;
  logic [D-1:0] v_q;
  logic [FLAG_DELAY:0][3:0] fl_q;
  logic [1:0] z_q;
  logic loadf, run, row_first, row_last, col_first, col_last;
  assign loadf     = state_q == LOADF;
  assign run       = state_q == RUN;
  assign row_first = r_q == '0;
  assign row_last  = r_q == h_q - W_SIZE'(1);
  assign col_first = c_q == '0;
  assign col_last  = c_q == w_q - W_SIZE'(1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? LOADF : IDLE;
      LOADF:   state_d = cnt_q == 2'(Tin - 1) ? GAP : LOADF;
      GAP:     state_d = CHG;
      CHG:     state_d = RUN;
      RUN:     state_d = row_last && col_last ? DRAIN : RUN;
      DRAIN:   state_d = v_q == '0 ? DONE : DRAIN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      w_q      <= '0;
      h_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      ld_q     <= 1'b0;
      ld_idx_q <= '0;
      v_q      <= '0;
      fl_q     <= '0;
      z_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        w_q   <= cfg_width;
        h_q   <= cfg_height;
        r_q   <= '0;
        c_q   <= '0;
        cnt_q <= '0;
      end
      if (loadf) cnt_q <= cnt_q + 2'd1;
      if (run) begin
        c_q <= col_last ? '0 : c_q + W_SIZE'(1);
        if (col_last) r_q <= r_q + W_SIZE'(1);
      end
      ld_q     <= loadf;
      ld_idx_q <= flt_rd_idx;
      // v_q[0] marks a data beat; later stages time the flags and t_cal_start
      v_q      <= {v_q[D-2:0], run};
      fl_q     <= {fl_q[FLAG_DELAY-1:0], run ? {row_first, row_last, col_first, col_last} : 4'b0};
      z_q      <= {row_last, row_first};
    end
  end
  assign busy                = state_q != IDLE && state_q != DONE;
  assign done                = state_q == DONE;
  assign flt_rd_en           = loadf;
  assign flt_rd_idx          = loadf ? cnt_q : '0;
  assign ifm_rd_en           = run;
  assign ifm_rd_row          = run ? r_q : '0;
  assign ifm_rd_col          = run ? c_q : '0;
  assign load_filter         = ld_q;
  assign load_idx            = ld_idx_q;
  assign bm_filter_data_flat = ld_q ? flt_rd_data : '0;
  assign change_filter       = state_q == CHG;
  assign t_data_run          = v_q[0];
  assign t_cal_start         = v_q[CAL_DELAY];
  // slot0 (row r-1) and slot2 (row r+1) are the vertical padding rows
  assign bm_ifm_data_flat    = v_q[0] ? ifm_rd_data & {{IFM_DW{~z_q[1]}}, {IFM_DW{1'b1}}, {IFM_DW{~z_q[0]}}} : '0;
  assign {c_is_first_row, c_is_last_row, c_is_first_col, c_is_last_col} = fl_q[FLAG_DELAY];
endmodule

// File: tb/tb_conv_pe_feeder.sv
// tb_conv_pe_feeder: scoreboard bench for conv_pe_feeder with buffer memory models.
module tb_conv_pe_feeder;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [9:0] cfg_width = '0, cfg_height = '0;
  logic busy, done, flt_rd_en, ifm_rd_en, load_filter, change_filter, t_data_run, t_cal_start;
  logic [1:0] flt_rd_idx, load_idx;
  logic [287:0] flt_rd_data = '0, bm_filter_data_flat;
  logic [9:0] ifm_rd_row, ifm_rd_col;
  logic [95:0] ifm_rd_data = '0, bm_ifm_data_flat;
  logic c_is_first_row, c_is_last_row, c_is_first_col, c_is_last_col;
  always #5 clk = ~clk;
  conv_pe_feeder dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .busy(busy), .done(done), .flt_rd_en(flt_rd_en), .flt_rd_idx(flt_rd_idx),
    .flt_rd_data(flt_rd_data), .ifm_rd_en(ifm_rd_en), .ifm_rd_row(ifm_rd_row),
    .ifm_rd_col(ifm_rd_col), .ifm_rd_data(ifm_rd_data), .load_filter(load_filter),
    .load_idx(load_idx), .bm_filter_data_flat(bm_filter_data_flat), .change_filter(change_filter),
    .t_data_run(t_data_run), .t_cal_start(t_cal_start), .bm_ifm_data_flat(bm_ifm_data_flat),
    .c_is_first_row(c_is_first_row), .c_is_last_row(c_is_last_row),
    .c_is_first_col(c_is_first_col), .c_is_last_col(c_is_last_col)
  );
  typedef struct {logic [95:0] d; logic [3:0] f;} beat_t;
  beat_t dq[$];
  int fq[$];
  int n_chk = 0, n_err = 0, n_done = 0, n_cal = 0, n_ld = 0, n_chg = 0;
  int cyc = 0, fcyc = 0, tile_hw = 0;
  bit mon_en = 0, first_seen = 0;
  logic [3:0] fp0 = '0, fp1 = '0, fp2 = '0, ef;
  logic pld = 1'b0;
  logic [1:0] pidx = '0;
  wire [131:0] all_out = {busy, done, flt_rd_en, flt_rd_idx, ifm_rd_en, ifm_rd_row, ifm_rd_col,
    load_filter, load_idx, change_filter, t_data_run, t_cal_start, c_is_first_row, c_is_last_row,
    c_is_first_col, c_is_last_col, bm_ifm_data_flat};
  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] wd(input int i, input logic [9:0] r, input logic [9:0] c);
    return {4'(i), 2'b0, r, c, 6'h15};
  endfunction
  function automatic logic [95:0] ipat(input logic [9:0] r, input logic [9:0] c);
    return {wd(2, r, c), wd(1, r, c), wd(0, r, c)};
  endfunction
  function automatic logic [287:0] fpat(input logic [1:0] i);
    logic [287:0] v;
    for (int j = 0; j < 9; j++) v[j*32 +: 32] = {16'hF17E, 8'(j), 6'b0, i};
    return v;
  endfunction
  // filter and line buffer models: data one cycle after the read strobe
  always @(posedge clk) begin
    flt_rd_data <= flt_rd_en ? fpat(flt_rd_idx) : '0;
    ifm_rd_data <= ifm_rd_en ? ipat(ifm_rd_row, ifm_rd_col) : '0;
  end
  always @(negedge clk) if (mon_en) begin
    beat_t b;
    int d;
    cyc++;
    if (done) n_done++;
    if (t_cal_start) n_cal++;
    if (load_filter) begin
      n_ld++;
      if (fq.size() == 0) chk("filter_underflow", 1, 0);
      else begin
        d = fq.pop_front();
        chk("load_idx", load_idx, d);
        chk("filter_data", bm_filter_data_flat, fpat(2'(d)));
      end
    end else chk("filter_zero", bm_filter_data_flat, 0);
    if (change_filter) begin
      n_chg++;
      chk("chg_after_last_load", {pld, pidx}, {1'b1, 2'd3});
    end
    pld = load_filter;
    pidx = load_idx;
    ef = '0;
    if (t_data_run) begin
      if (!first_seen) begin first_seen = 1; fcyc = cyc; end
      if (dq.size() == 0) chk("beat_underflow", 1, 0);
      else begin
        b = dq.pop_front();
        chk("ifm_data", bm_ifm_data_flat, b.d);
        ef = b.f;
      end
    end
    fp2 = fp1; fp1 = fp0; fp0 = ef;
    chk("flags", {c_is_first_row, c_is_last_row, c_is_first_col, c_is_last_col}, fp2);
    if (first_seen) begin
      d = cyc - fcyc;
      chk("data_run", t_data_run, d < tile_hw);
      chk("cal_start", t_cal_start, d >= 3 && d < 3 + tile_hw);
    end
  end
  // mode 0: plain, 1: start pulsed during RUN, 2: start pulsed in the done cycle
  task automatic run_tile(input int w, input int h, input int mode);
    beat_t b;
    int k, d0;
    for (int i = 0; i < 4; i++) fq.push_back(i);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        b.d = ipat(10'(r), 10'(c));
        if (r == 0) b.d[31:0] = '0;
        if (r == h - 1) b.d[95:64] = '0;
        b.f = {r == 0, r == h - 1, c == 0, c == w - 1};
        dq.push_back(b);
      end
    tile_hw = w * h; first_seen = 0; n_cal = 0; n_ld = 0; n_chg = 0; d0 = n_done;
    cfg_width = 10'(w); cfg_height = 10'(h); start = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      start = mode == 1 && k == 10;
      if (start) chk("busy_in_run", busy, 1);
    end while (!done && k < 3000);
    if (!done) chk("done_timeout", 0, 1);
    chk("busy_at_done", busy, 0);
    chk("beats_left", dq.size(), 0);
    chk("filters_left", fq.size(), 0);
    chk("cal_cycles", n_cal, tile_hw);
    chk("load_beats", n_ld, 4);
    chk("chg_pulses", n_chg, 1);
    start = mode == 2;
    @(negedge clk);
    start = 1'b0;
    chk("done_once", n_done - d0, 1);
    if (mode == 2) repeat (3) begin
      @(negedge clk);
      chk("busy_after_done_start", busy, 0);
    end
  endtask
  initial begin
    int d0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_out, 0);
    chk("reset_filter", bm_filter_data_flat, 0);
    rstn = 1'b1;
    @(negedge clk);
    mon_en = 1;
    run_tile(16, 3, 0);
    run_tile(1, 1, 0);
    run_tile(5, 3, 1);
    run_tile(3, 2, 2);
    // abort a tile mid-RUN
    cfg_width = 10'd16; cfg_height = 10'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mon_en = 0;
    repeat (12) @(negedge clk);
    chk("busy_before_abort", ifm_rd_en, 1);
    d0 = n_done;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_outputs", all_out, 0);
    chk("abort_filter", bm_filter_data_flat, 0);
    @(negedge clk);
    rstn = 1'b1;
    dq.delete(); fq.delete();
    fp0 = '0; fp1 = '0; fp2 = '0; pld = 1'b0; pidx = '0; first_seen = 0;
    @(negedge clk);
    chk("no_done_on_abort", n_done, d0);
    mon_en = 1;
    run_tile(6, 2, 0);
    run_tile(4, 2, 0);
    run_tile(4, 2, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
